// File: rtl/katp_regfile_pkg.sv
// Shared definitions for the register-pair transfer controller.
// Macro XFER_SWAP_EN adds the SWAP8 states to the state encoding.
package katp_regfile_pkg;

  localparam logic [1:0] MODE_MOVE8  = 2'b00;
  localparam logic [1:0] MODE_MOVE16 = 2'b01;
  localparam logic [1:0] MODE_LOADI8 = 2'b10;
  localparam logic [1:0] MODE_SWAP8  = 2'b11;

  localparam logic HALF_L = 1'b0;
  localparam logic HALF_H = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2
`ifdef XFER_SWAP_EN
    ,
    SW_RD2 = 3'd3,
    SW_WR1 = 3'd4,
    SW_WR2 = 3'd5
`endif
  } xfer_state_t;

  typedef enum logic [1:0] {
    KIND_READ8   = 2'd0,
    KIND_WRITE8  = 2'd1,
    KIND_READ16  = 2'd2,
    KIND_WRITE16 = 2'd3
  } cs_kind_t;

  // True when a pair index addresses an existing pair.
  function automatic logic index_ok(input int unsigned idx, input int unsigned npairs);
    return idx < npairs;
  endfunction

  // True for the kinds that act on a whole pair rather than one half.
  function automatic logic kind_is16(input cs_kind_t kind);
    return (kind == KIND_READ16) || (kind == KIND_WRITE16);
  endfunction

endpackage

// File: rtl/cs_decode.sv
// Turns a {pair index, half} selector plus an access kind into
// one-hot per-pair chip-select vectors for the L, H and 16-bit ports.
module cs_decode
  import katp_regfile_pkg::*;
#(
  parameter int NPAIRS = 4,
  localparam int IW = $clog2(NPAIRS)
) (
  input  logic [IW:0]       sel,
  input  cs_kind_t          kind,
  input  logic              en,
  output logic [NPAIRS-1:0] cs_l,
  output logic [NPAIRS-1:0] cs_h,
  output logic [NPAIRS-1:0] cs_16
);

  logic [IW-1:0] idx;

  assign idx = sel[IW:1];

  // Raise exactly one select for the addressed pair; 16-bit kinds ignore the half bit.
  always_comb begin
    cs_l  = '0;
    cs_h  = '0;
    cs_16 = '0;
    for (int i = 0; i < NPAIRS; i++) begin
      if (en && (idx == IW'(i))) begin
        if (kind_is16(kind)) begin
          cs_16[i] = 1'b1;
        end else if (sel[0] == HALF_L) begin
          cs_l[i] = 1'b1;
        end else begin
          cs_h[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_xfer_ctrl.sv
// Bus-transfer initiator for an array of DoubleRegister8 pairs.
// Sequences MOVE8 / MOVE16 / LOADI8 (and SWAP8 when XFER_SWAP_EN is
// defined) as registered chip selects around the pairs' read latency.
module regfile_xfer_ctrl
  import katp_regfile_pkg::*;
#(
  parameter int NPAIRS = 4,
  localparam int IW = $clog2(NPAIRS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [IW:0]       cmd_src,
  input  logic [IW:0]       cmd_dst,
  input  logic [7:0]        cmd_imm,
  input  logic [7:0]        bus8_rd,
  output logic [7:0]        bus8_drv,
  output logic              bus8_oe,
  output logic [NPAIRS-1:0] cs_l_in,
  output logic [NPAIRS-1:0] cs_h_in,
  output logic [NPAIRS-1:0] cs_16_in,
  output logic [NPAIRS-1:0] cs_l_1,
  output logic [NPAIRS-1:0] cs_h_1,
  output logic [NPAIRS-1:0] cs_16_1,
  output logic              done,
  output logic              cmd_err
);

  xfer_state_t state, state_n;
  logic [1:0]  mode_q;
  logic [IW:0] src_q, dst_q;

`ifdef XFER_SWAP_EN
  logic [7:0] tmp;
`else
  logic bus_unused;
  assign bus_unused = ^bus8_rd;
`endif

  logic accept, cmd_bad, src_bad, dst_bad, mode_bad;

  logic        rd_en, wr_en;
  cs_kind_t    rd_kind, wr_kind;
  logic [IW:0] rd_sel, wr_sel;
  logic        oe_n, done_n, err_n, ready_n;
  logic [7:0]  drv_n;

  logic [NPAIRS-1:0] rd_l_n, rd_h_n, rd_16_n;
  logic [NPAIRS-1:0] wr_l_n, wr_h_n, wr_16_n;

  assign accept  = cmd_valid & cmd_ready;
  assign src_bad = !index_ok(32'(cmd_src[IW:1]), NPAIRS);
  assign dst_bad = !index_ok(32'(cmd_dst[IW:1]), NPAIRS);
`ifdef XFER_SWAP_EN
  assign mode_bad = 1'b0;
`else
  assign mode_bad = (cmd_mode == MODE_SWAP8);
`endif
  assign cmd_bad = mode_bad || dst_bad || ((cmd_mode != MODE_LOADI8) && src_bad);

  // Decide what the next cycle does: next state, which selects to raise and the strobes.
  always_comb begin
    state_n = state;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_kind = KIND_READ8;
    wr_kind = KIND_WRITE8;
    rd_sel  = src_q;
    wr_sel  = dst_q;
    oe_n    = 1'b0;
    drv_n   = 8'h00;
    done_n  = 1'b0;
    err_n   = 1'b0;
    ready_n = cmd_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_bad) begin
            err_n = 1'b1;
          end else begin
            case (cmd_mode)
              MODE_MOVE8: begin
                state_n = RD;
                ready_n = 1'b0;
                rd_en   = 1'b1;
                rd_sel  = cmd_src;
              end
              MODE_MOVE16: begin
                state_n = RD;
                ready_n = 1'b0;
                rd_en   = 1'b1;
                rd_kind = KIND_READ16;
                rd_sel  = cmd_src;
                wr_en   = 1'b1;
                wr_kind = KIND_WRITE16;
                wr_sel  = cmd_dst;
                done_n  = 1'b1;
              end
              MODE_LOADI8: begin
                state_n = WR;
                ready_n = 1'b0;
                wr_en   = 1'b1;
                wr_sel  = cmd_dst;
                oe_n    = 1'b1;
                drv_n   = cmd_imm;
                done_n  = 1'b1;
              end
`ifdef XFER_SWAP_EN
              MODE_SWAP8: begin
                state_n = RD;
                ready_n = 1'b0;
                rd_en   = 1'b1;
                rd_sel  = cmd_src;
              end
`endif
              default: begin
                state_n = IDLE;
              end
            endcase
          end
        end
      end
      RD: begin
        if (mode_q == MODE_MOVE16) begin
          state_n = IDLE;
          ready_n = 1'b1;
`ifdef XFER_SWAP_EN
        end else if (mode_q == MODE_SWAP8) begin
          state_n = SW_RD2;
          rd_en   = 1'b1;
          rd_sel  = dst_q;
`endif
        end else begin
          state_n = WR;
          wr_en   = 1'b1;
          wr_sel  = dst_q;
          done_n  = 1'b1;
        end
      end
      WR: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
`ifdef XFER_SWAP_EN
      SW_RD2: begin
        state_n = SW_WR1;
        wr_en   = 1'b1;
        wr_sel  = src_q;
      end
      SW_WR1: begin
        state_n = SW_WR2;
        wr_en   = 1'b1;
        wr_sel  = dst_q;
        oe_n    = 1'b1;
        drv_n   = tmp;
        done_n  = 1'b1;
      end
      SW_WR2: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
`endif
      default: begin
        state_n = IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  cs_decode #(.NPAIRS(NPAIRS)) u_rd_decode (
    .sel   (rd_sel),
    .kind  (rd_kind),
    .en    (rd_en),
    .cs_l  (rd_l_n),
    .cs_h  (rd_h_n),
    .cs_16 (rd_16_n)
  );

  cs_decode #(.NPAIRS(NPAIRS)) u_wr_decode (
    .sel   (wr_sel),
    .kind  (wr_kind),
    .en    (wr_en),
    .cs_l  (wr_l_n),
    .cs_h  (wr_h_n),
    .cs_16 (wr_16_n)
  );

  // Register state, every output and the captured command so nothing reaches the pairs combinationally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      cs_l_1    <= '0;
      cs_h_1    <= '0;
      cs_16_1   <= '0;
      cs_l_in   <= '0;
      cs_h_in   <= '0;
      cs_16_in  <= '0;
      bus8_oe   <= 1'b0;
      bus8_drv  <= 8'h00;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
      mode_q    <= MODE_MOVE8;
      src_q     <= '0;
      dst_q     <= '0;
`ifdef XFER_SWAP_EN
      tmp       <= 8'h00;
`endif
    end else begin
      state     <= state_n;
      cmd_ready <= ready_n;
      cs_l_1    <= rd_l_n;
      cs_h_1    <= rd_h_n;
      cs_16_1   <= rd_16_n;
      cs_l_in   <= wr_l_n;
      cs_h_in   <= wr_h_n;
      cs_16_in  <= wr_16_n;
      bus8_oe   <= oe_n;
      bus8_drv  <= drv_n;
      done      <= done_n;
      cmd_err   <= err_n;
      if (accept) begin
        mode_q <= cmd_mode;
        src_q  <= cmd_src;
        dst_q  <= cmd_dst;
      end
`ifdef XFER_SWAP_EN
      if (state == SW_RD2) begin
        tmp <= bus8_rd;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_xfer_ctrl.sv
// Self-checking bench for regfile_xfer_ctrl with a behavioural pair array.
// Honours XFER_SWAP_EN the same way as the design.
module tb_regfile_xfer_ctrl;
  import katp_regfile_pkg::*;

  localparam int NPAIRS = 6;
  localparam int IW = $clog2(NPAIRS);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd_mode;
  logic [IW:0]       cmd_src, cmd_dst;
  logic [7:0]        cmd_imm, bus8_rd, bus8_drv;
  logic              bus8_oe, done, cmd_err;
  logic [NPAIRS-1:0] cs_l_in, cs_h_in, cs_16_in, cs_l_1, cs_h_1, cs_16_1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  regfile_xfer_ctrl #(.NPAIRS(NPAIRS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .bus8_rd(bus8_rd), .bus8_drv(bus8_drv), .bus8_oe(bus8_oe),
    .cs_l_in(cs_l_in), .cs_h_in(cs_h_in), .cs_16_in(cs_16_in),
    .cs_l_1(cs_l_1), .cs_h_1(cs_h_1), .cs_16_1(cs_16_1),
    .done(done), .cmd_err(cmd_err)
  );

  // Behavioural register-pair array on the shared nets
  logic [7:0]  env_l [NPAIRS];
  logic [7:0]  env_h [NPAIRS];
  logic [7:0]  rd_q;
  logic        rd_drive;
  logic        env_clear;
  logic [7:0]  bus8_net;
  logic [15:0] bus16_net;

  assign bus8_rd  = rd_drive ? rd_q : 8'h00;
  assign bus8_net = bus8_oe ? bus8_drv : bus8_rd;

  // 16-bit read port is combinational
  always_comb begin
    bus16_net = 16'h0000;
    for (int i = 0; i < NPAIRS; i++)
      if (cs_16_1[i]) bus16_net = bus16_net | {env_h[i], env_l[i]};
  end

  // Pairs: registered 8-bit read port, writes captured from the nets
  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < NPAIRS; i++) begin
        env_l[i] <= 8'h00;
        env_h[i] <= 8'h00;
      end
      rd_q     <= 8'h00;
      rd_drive <= 1'b0;
    end else begin
      rd_drive <= 1'b0;
      for (int i = 0; i < NPAIRS; i++) begin
        if (cs_l_1[i]) begin rd_q <= env_l[i]; rd_drive <= 1'b1; end
        if (cs_h_1[i]) begin rd_q <= env_h[i]; rd_drive <= 1'b1; end
        if (cs_l_in[i]) env_l[i] <= bus8_net;
        if (cs_h_in[i]) env_h[i] <= bus8_net;
        if (cs_16_in[i]) {env_h[i], env_l[i]} <= bus16_net;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of register contents and scoreboard
  logic [7:0] mdl_l [NPAIRS];
  logic [7:0] mdl_h [NPAIRS];

  typedef struct {
    logic                   is_err;
    int                     push_cyc;
    int                     lat;
    logic [NPAIRS*16-1:0]   snap;
    logic [NPAIRS-1:0]      wl, wh, w16, r16;
    logic                   oe;
    logic [7:0]             drv;
  } exp_t;

  exp_t sb[$];

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [IW:0] sel(input int idx, input logic half);
    return {IW'(idx), half};
  endfunction

  function automatic logic [7:0] get8(input logic [IW:0] s);
    int i;
    i = int'(s[IW:1]);
    return s[0] ? mdl_h[i] : mdl_l[i];
  endfunction

  function automatic void set8(input logic [IW:0] s, input logic [7:0] v);
    int i;
    i = int'(s[IW:1]);
    if (s[0]) mdl_h[i] = v;
    else      mdl_l[i] = v;
  endfunction

  function automatic logic [NPAIRS*16-1:0] pack_env();
    logic [NPAIRS*16-1:0] v;
    for (int i = 0; i < NPAIRS; i++) v[i*16 +: 16] = {env_h[i], env_l[i]};
    return v;
  endfunction

  function automatic logic [NPAIRS*16-1:0] pack_mdl();
    logic [NPAIRS*16-1:0] v;
    for (int i = 0; i < NPAIRS; i++) v[i*16 +: 16] = {mdl_h[i], mdl_l[i]};
    return v;
  endfunction

  // Issue one command at a negedge; push its expected outcome first
  task automatic applyStimulus(input logic [1:0] mode, input logic [IW:0] src,
                               input logic [IW:0] dst, input logic [7:0] imm);
    int n = 0;
    int si, di;
    logic bad;
    logic [7:0] a, b;
    logic [15:0] w;
    exp_t e;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checkOutput("ready_timeout", 0, 1);
      return;
    end
    si = int'(src[IW:1]);
    di = int'(dst[IW:1]);
    e.is_err = 1'b0; e.push_cyc = cyc; e.lat = 1;
    e.wl = '0; e.wh = '0; e.w16 = '0; e.r16 = '0; e.oe = 1'b0; e.drv = 8'h00;
    bad = (di >= NPAIRS) || ((mode != MODE_LOADI8) && (si >= NPAIRS));
`ifndef XFER_SWAP_EN
    if (mode == MODE_SWAP8) bad = 1'b1;
`endif
    if (bad) begin
      e.is_err = 1'b1;
    end else begin
      case (mode)
        MODE_MOVE8: begin
          set8(dst, get8(src));
          e.lat = 2;
        end
        MODE_MOVE16: begin
          w = {mdl_h[si], mdl_l[si]};
          {mdl_h[di], mdl_l[di]} = w;
          e.w16[di] = 1'b1;
          e.r16[si] = 1'b1;
        end
        MODE_LOADI8: begin
          set8(dst, imm);
          e.oe = 1'b1;
          e.drv = imm;
        end
        default: begin
          a = get8(src);
          b = get8(dst);
          set8(src, b);
          set8(dst, a);
          e.lat = 4;
          e.oe = 1'b1;
          e.drv = a;
        end
      endcase
      if (mode != MODE_MOVE16) begin
        if (dst[0]) e.wh[di] = 1'b1;
        else        e.wl[di] = 1'b1;
      end
    end
    e.snap = pack_mdl();
    sb.push_back(e);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_imm   = imm;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on done/cmd_err and checks bus protocol each cycle
  logic                 pend_chk = 1'b0;
  logic                 ready_chk = 1'b0;
  logic [NPAIRS*16-1:0] pend_snap;

  always @(negedge clk) begin : monitor
    exp_t e;
    int nr, n16r, n16w;
    logic ok;
    if (rst_n) begin
      if (pend_chk) begin
        checkOutput("regs", pack_env(), pend_snap);
        pend_chk = 1'b0;
      end
      if (ready_chk) begin
        checkOutput("ready_after_done", cmd_ready, 1);
        ready_chk = 1'b0;
      end
      if (done || cmd_err) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_pulse", {done, cmd_err}, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_kind", {done, cmd_err}, e.is_err ? 2'b01 : 2'b10);
          checkOutput("latency", cyc - e.push_cyc, e.lat);
          checkOutput("cs_l_in", cs_l_in, e.wl);
          checkOutput("cs_h_in", cs_h_in, e.wh);
          checkOutput("cs_16_in", cs_16_in, e.w16);
          checkOutput("cs_16_1", cs_16_1, e.r16);
          checkOutput("bus8_oe", bus8_oe, e.oe);
          if (e.oe) checkOutput("bus8_drv", bus8_drv, e.drv);
          if (!e.is_err) begin
            checkOutput("ready_low_at_done", cmd_ready, 0);
            ready_chk = 1'b1;
          end
          pend_snap = e.snap;
          pend_chk  = 1'b1;
        end
      end
      nr   = $countones({cs_l_1, cs_h_1, cs_l_in, cs_h_in});
      n16r = $countones(cs_16_1);
      n16w = $countones(cs_16_in);
      if (nr + n16r + n16w > 0) begin
        ok = (n16r + n16w > 0) ? (n16r == 1 && n16w == 1 && nr == 0) : (nr == 1);
        checkOutput("cs_onehot", ok, 1);
      end
      if (bus8_oe) checkOutput("net_contention", rd_drive, 0);
    end else begin
      pend_chk  = 1'b0;
      ready_chk = 1'b0;
    end
  end

  initial begin
    int n;
    int si, di;
    rst_n = 1'b0;
    env_clear = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode = 2'b00;
    cmd_src = '0;
    cmd_dst = '0;
    cmd_imm = 8'h00;
    for (int i = 0; i < NPAIRS; i++) begin
      mdl_l[i] = 8'h00;
      mdl_h[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_cs", {cs_l_in, cs_h_in, cs_16_in, cs_l_1, cs_h_1, cs_16_1}, 0);
    checkOutput("reset_oe_drv", {bus8_oe, bus8_drv}, 0);
    checkOutput("reset_done_err", {done, cmd_err}, 0);
    checkOutput("reset_ready", cmd_ready, 1);
    env_clear = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios; LOADI8 ignores an out-of-range src index
    applyStimulus(MODE_LOADI8, sel(7, HALF_L), sel(1, HALF_L), 8'h5A);
    applyStimulus(MODE_MOVE8,  sel(1, HALF_L), sel(2, HALF_H), 8'h00);
    applyStimulus(MODE_LOADI8, sel(0, HALF_L), sel(0, HALF_L), 8'hEF);
    applyStimulus(MODE_LOADI8, sel(0, HALF_L), sel(0, HALF_H), 8'hBE);
    applyStimulus(MODE_MOVE16, sel(0, HALF_L), sel(3, HALF_H), 8'h00);
    applyStimulus(MODE_LOADI8, sel(0, HALF_L), sel(0, HALF_L), 8'hC3);
    applyStimulus(MODE_LOADI8, sel(0, HALF_L), sel(1, HALF_L), 8'h11);
    applyStimulus(MODE_LOADI8, sel(0, HALF_L), sel(1, HALF_H), 8'h22);
    applyStimulus(MODE_SWAP8,  sel(1, HALF_L), sel(1, HALF_H), 8'h00);
    applyStimulus(MODE_MOVE8,  sel(6, HALF_L), sel(2, HALF_L), 8'h00);
    applyStimulus(MODE_MOVE16, sel(1, HALF_L), sel(7, HALF_L), 8'h00);
    applyStimulus(MODE_MOVE8,  sel(2, HALF_H), sel(2, HALF_H), 8'h00);
    applyStimulus(MODE_MOVE16, sel(3, HALF_L), sel(3, HALF_L), 8'h00);
    applyStimulus(MODE_SWAP8,  sel(2, HALF_H), sel(2, HALF_H), 8'h00);

    // Reset in the middle of a command aborts it without writes or done
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
`ifdef XFER_SWAP_EN
    cmd_mode = MODE_SWAP8;
`else
    cmd_mode = MODE_MOVE8;
`endif
    cmd_src = sel(1, HALF_L);
    cmd_dst = sel(5, HALF_H);
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
`ifdef XFER_SWAP_EN
    @(negedge clk);
`endif
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_cs", {cs_l_in, cs_h_in, cs_16_in, cs_l_1, cs_h_1, cs_16_1}, 0);
    checkOutput("abort_oe", bus8_oe, 0);
    checkOutput("abort_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", cmd_ready, 1);
    repeat (6) @(negedge clk);
    checkOutput("abort_regs", pack_env(), pack_mdl());

    // Random register contents, then random commands
    for (int i = 0; i < NPAIRS; i++) begin
      applyStimulus(MODE_LOADI8, sel(0, HALF_L), sel(i, HALF_L), 8'($urandom));
      applyStimulus(MODE_LOADI8, sel(0, HALF_L), sel(i, HALF_H), 8'($urandom));
    end
    for (int k = 0; k < 200; k++) begin
      si = ($urandom_range(0, 9) == 0) ? $urandom_range(NPAIRS, (1 << IW) - 1) : $urandom_range(0, NPAIRS - 1);
      di = ($urandom_range(0, 9) == 0) ? $urandom_range(NPAIRS, (1 << IW) - 1) : $urandom_range(0, NPAIRS - 1);
      applyStimulus(2'($urandom_range(0, 3)), sel(si, 1'($urandom_range(0, 1))),
                    sel(di, 1'($urandom_range(0, 1))), 8'($urandom));
    end

    n = 0;
    while ((sb.size() != 0 || pend_chk) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
